// File: rtl/lzc_pkg.sv
// lzc_pkg: FSM states and result-width helper shared across the LZC family
package lzc_pkg;
  typedef enum logic [1:0] {IDLE, SCAN, DONE} lzc_state_t;
  function automatic int lzc_cnt_w(input int width);
    return $clog2(width) + 1;
  endfunction
endpackage

// File: rtl/lzc_chunk.sv
// lzc_chunk: combinational leading-zero count of one CHUNK-bit slice (z=CHUNK when all zero)
module lzc_chunk #(
  parameter int CHUNK = 16,
  localparam int ZW = $clog2(CHUNK) + 1
) (
  input  logic [CHUNK-1:0] d,
  output logic [ZW-1:0]    z,
  output logic             nz
);
  always_comb begin
    z = ZW'(CHUNK);
    for (int i = 0; i < CHUNK; i++)
      if (d[i]) z = ZW'(CHUNK - 1 - i);
  end
  assign nz = |d;
endmodule

// File: rtl/lzc_seq_ctrl.sv
// lzc_seq_ctrl: MSB-first sliced leading-zero-count sequencer with valid/ready handshakes.
// Define LZC_EARLY_EXIT_EN to stop scanning at the first nonzero slice.
module lzc_seq_ctrl
  import lzc_pkg::*;
#(
  parameter int WIDTH = 64,
  parameter int CHUNK = 16,
  localparam int NSLICE = WIDTH / CHUNK,
  localparam int CNT_W = lzc_cnt_w(WIDTH),
  localparam int IDX_W = $clog2(NSLICE),
  localparam int ZW = $clog2(CHUNK) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [CNT_W-1:0] out_count,
  output logic             out_zero,
  output logic             busy
);
  if (WIDTH % CHUNK != 0) begin : g_bad_div
    $error("WIDTH must be a multiple of CHUNK");
  end
  if (CHUNK < 2 || (CHUNK & (CHUNK - 1)) != 0) begin : g_bad_chunk
    $error("CHUNK must be a power of 2, >= 2");
  end
  if (NSLICE < 2) begin : g_bad_nslice
    $error("WIDTH/CHUNK must be >= 2");
  end
  lzc_state_t       state_q, state_d;
  logic [WIDTH-1:0] sh_q, sh_d;
  logic [CNT_W-1:0] acc_q, acc_d, out_count_q, out_count_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             found_q, found_d, out_valid_q, out_valid_d, out_zero_q, out_zero_d;
  logic [ZW-1:0]    z;
  logic             nz, last;
  lzc_chunk #(.CHUNK(CHUNK)) u_core (.d(sh_q[WIDTH-1 -: CHUNK]), .z(z), .nz(nz));
`ifdef LZC_EARLY_EXIT_EN
  assign last = nz || idx_q == IDX_W'(NSLICE - 1);
`else
  assign last = idx_q == IDX_W'(NSLICE - 1);
`endif
  assign in_ready  = rst_n & (state_q == IDLE);
  assign busy      = state_q != IDLE;
  assign out_valid = out_valid_q;
  assign out_count = out_count_q;
  assign out_zero  = out_zero_q;
  always_comb begin
    state_d     = state_q;
    sh_d        = sh_q;
    acc_d       = acc_q;
    idx_d       = idx_q;
    found_d     = found_q;
    out_valid_d = out_valid_q;
    out_count_d = out_count_q;
    out_zero_d  = out_zero_q;
    case (state_q)
      IDLE: if (in_valid && in_ready) begin
        state_d = SCAN;
        sh_d    = in_data;
        acc_d   = '0;
        idx_d   = '0;
        found_d = 1'b0;
      end
      SCAN: begin
        // once a set bit is seen the count is final; later slices only advance the scan
        acc_d   = found_q ? acc_q : acc_q + CNT_W'(z);
        found_d = found_q | nz;
        sh_d    = sh_q << CHUNK;
        idx_d   = last ? idx_q : idx_q + IDX_W'(1);
        if (last) begin
          state_d     = DONE;
          out_valid_d = 1'b1;
          out_count_d = acc_d;
          out_zero_d  = acc_d == CNT_W'(WIDTH);
        end
      end
      DONE: if (out_ready) begin
        state_d     = IDLE;
        out_valid_d = 1'b0;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      sh_q        <= '0;
      acc_q       <= '0;
      idx_q       <= '0;
      found_q     <= 1'b0;
      out_valid_q <= 1'b0;
      out_count_q <= '0;
      out_zero_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      sh_q        <= sh_d;
      acc_q       <= acc_d;
      idx_q       <= idx_d;
      found_q     <= found_d;
      out_valid_q <= out_valid_d;
      out_count_q <= out_count_d;
      out_zero_q  <= out_zero_d;
    end
  end
endmodule

// File: tb/tb_lzc_seq_ctrl.sv
// tb_lzc_seq_ctrl: directed and random checks of lzc_seq_ctrl against a transaction-level model
module tb_lzc_seq_ctrl;
`ifdef LZC_EARLY_EXIT_EN
  localparam bit EE = 1'b1;
`else
  localparam bit EE = 1'b0;
`endif
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [63:0] in_data = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [6:0]  out_count;
  logic        out_zero;
  logic        busy;
  int n_chk = 0;
  int n_fail = 0;
  lzc_seq_ctrl #(.WIDTH(64), .CHUNK(16)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_count(out_count), .out_zero(out_zero),
    .busy(busy)
  );
  always #5 clk = ~clk;
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
    end
  endtask
  function automatic int lzc64(input logic [63:0] d);
    for (int i = 63; i >= 0; i--) if (d[i]) return 63 - i;
    return 64;
  endfunction
  function automatic int lat_of(input logic [63:0] d);
    if (!EE || d == 0) return 4;
    return lzc64(d) / 16 + 1;
  endfunction
  // transaction-level model: one operand in flight, result appears after lat_of() edges
  bit started = 1'b0;
  bit rst_edge = 1'b0;
  bit m_busy = 1'b0;
  bit m_valid = 1'b0;
  int m_cnt = 0;
  int m_left = 0;
  logic [6:0] res_q[$];
  always @(posedge clk) begin
    if (!rst_n) begin
      started  <= 1'b1;
      rst_edge <= 1'b1;
      m_busy   <= 1'b0;
      m_valid  <= 1'b0;
    end else begin
      rst_edge <= 1'b0;
      if (m_valid && out_ready) begin
        m_valid <= 1'b0;
        m_busy  <= 1'b0;
      end else if (!m_busy && in_valid) begin
        m_busy <= 1'b1;
        m_cnt  <= lzc64(in_data);
        m_left <= lat_of(in_data);
      end else if (m_busy && !m_valid) begin
        m_left <= m_left - 1;
        if (m_left == 1) m_valid <= 1'b1;
      end
    end
  end
  always @(negedge clk) begin
    if (started) begin
      if (rst_edge) begin
        chk("rst_out_count", 64'(out_count), 0);
        chk("rst_out_zero", 64'(out_zero), 0);
      end
      chk("in_ready", 64'(in_ready), 64'(rst_n && !m_busy));
      chk("busy", 64'(busy), 64'(m_busy));
      chk("out_valid", 64'(out_valid), 64'(m_valid));
      if (m_valid) begin
        chk("out_count", 64'(out_count), 64'(m_cnt));
        chk("out_zero", 64'(out_zero), 64'(m_cnt == 64));
      end
      if (out_valid && out_ready) res_q.push_back(out_count);
    end
  end
  task automatic send(input logic [63:0] d);
    logic a;
    in_valid = 1'b1;
    in_data  = d;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk) a = in_ready;
      @(posedge clk);
      if (a) begin
        #1 in_valid = 1'b0;
        return;
      end
    end
    chk("accept_timeout", 0, 1);
    in_valid = 1'b0;
  endtask
  task automatic wait_valid(output int lat);
    lat = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      if (out_valid) return;
    end
    chk("valid_timeout", 0, 1);
  endtask
  task automatic release_out();
    @(posedge clk) #1 out_ready = 1'b1;
    @(posedge clk) #1 out_ready = 1'b0;
  endtask
  task automatic directed(input string nm, input logic [63:0] d, input int cnt, input int lat);
    int l;
    send(d);
    wait_valid(l);
    chk({nm, "_lat"}, 64'(l), 64'(lat));
    chk({nm, "_count"}, 64'(out_count), 64'(cnt));
    chk({nm, "_zero"}, 64'(out_zero), 64'(cnt == 64));
    release_out();
  endtask
  function automatic logic [63:0] rnd_op();
    logic [63:0] d;
    if ($urandom_range(7) == 0) return '0;
    for (int s = 0; s < 4; s++) begin
      case ($urandom_range(3))
        0: d[s*16 +: 16] = 16'h0;
        1: d[s*16 +: 16] = 16'h1 << $urandom_range(15);
        default: d[s*16 +: 16] = 16'($urandom);
      endcase
    end
    return d;
  endfunction
  initial begin
    int l;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    directed("t1_msb", 64'h8000_0000_0000_0000, 0, EE ? 1 : 4);
    directed("t2_mid", 64'h0000_0001_0000_0000, 31, EE ? 2 : 4);
    directed("t3_zero", 64'h0, 64, 4);
    send(64'h00F0_0000_0000_0000);
    wait_valid(l);
    in_valid = 1'b1;
    in_data  = '1;
    repeat (5) begin
      @(negedge clk);
      chk("t4_hold_valid", 64'(out_valid), 1);
      chk("t4_hold_count", 64'(out_count), 8);
      chk("t4_hold_in_ready", 64'(in_ready), 0);
    end
    release_out();
    send('1);
    wait_valid(l);
    chk("t4_next_count", 64'(out_count), 0);
    release_out();
    send(64'h0);
    @(posedge clk) #1 rst_n = 1'b0;
    @(posedge clk) #1 rst_n = 1'b1;
    @(negedge clk);
    chk("t5_busy", 64'(busy), 0);
    chk("t5_in_ready", 64'(in_ready), 1);
    repeat (8) @(negedge clk) chk("t5_no_result", 64'(out_valid), 0);
    res_q.delete();
    @(posedge clk) #1 out_ready = 1'b1;
    send(64'h1);
    send('1);
    repeat (12) @(negedge clk);
    chk("t6_n_results", 64'(res_q.size()), 2);
    if (res_q.size() == 2) begin
      chk("t6_first", 64'(res_q[0]), 63);
      chk("t6_second", 64'(res_q[1]), 0);
    end
    repeat (600) begin
      @(posedge clk) #1;
      rst_n     = $urandom_range(199) != 0;
      in_valid  = $urandom_range(1) != 0;
      in_data   = rnd_op();
      out_ready = $urandom_range(3) != 0;
    end
    @(posedge clk) #1;
    rst_n = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b1;
    repeat (10) @(posedge clk);
    @(negedge clk);
    chk("final_idle", 64'(busy), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
